// File: rtl/uart_pkg.sv
// Shared definitions for the UART echo buffer: runtime modes, TX FSM states
// and the ASCII constants used by the uppercase transform.
package uart_pkg;

    typedef enum logic [1:0] {
        MODE_ECHO  = 2'd0,
        MODE_UPPER = 2'd1,
        MODE_LINE  = 2'd2,
        MODE_MUTE  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } tx_state_e;

    localparam logic [7:0] ASCII_LOWER_A     = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z     = 8'h7A;
    localparam logic [7:0] ASCII_CASE_OFFSET = 8'h20;

endpackage

// File: rtl/uart_echo_buffer_if.sv
// Handshake bundle between UART_RX / UART_TX and the echo buffer.
// The slave modport is the echo buffer's view; master is the UART side.
interface uart_echo_buffer_if #(parameter int DATA_W = 8);

    logic              rx_finish;
    logic              rx_error;
    logic [DATA_W-1:0] rx_data;
    logic              tx_finish;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;

    modport master (
        output rx_finish, rx_error, rx_data, tx_finish,
        input  tx_start, tx_data
    );

    modport slave (
        input  rx_finish, rx_error, rx_data, tx_finish,
        output tx_start, tx_data
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
// Simultaneous read and write are both honoured; DEPTH must be a power of two.
module uart_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset; only the pointers define what is valid.
    always_ff @(posedge sys_clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_echo_buffer.sv
// FIFO-buffered RX-to-TX echo with echo/uppercase/line/mute modes.
// Optional error counter output enabled by defining UART_ECHO_ERRCNT_EN.
module uart_echo_buffer
    import uart_pkg::*;
#(
    parameter int               DATA_W     = 8,
    parameter int               DEPTH      = 16,
    parameter int               START_HOLD = 1736,
    parameter logic [DATA_W-1:0] CR_CODE   = 8'h0D
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic [1:0]             mode,
    uart_echo_buffer_if.slave      uart,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow,
    output logic                   busy
`ifdef UART_ECHO_ERRCNT_EN
    ,
    output logic [15:0]            err_count
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int HW = $clog2(START_HOLD + 1);

    logic [2:0]        rx_sync;
    logic [2:0]        tx_sync;
    logic              rx_evt;
    logic              tx_evt;
    logic [DATA_W-1:0] rx_byte;
    logic              accept;
    logic              wr_en;
    logic              ovf_drop;
    logic              pop;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head;
    logic [CW-1:0]     pending_lines;
    logic              release_ok;

    tx_state_e         state, state_next;
    logic [HW-1:0]     hold_cnt, hold_next;
    logic              start_q, start_next;
    logic [DATA_W-1:0] data_q, data_next;
    logic              seen_q, seen_next;

    // Bits [1:0] are the two-flop synchroniser, bit [2] remembers the previous level.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync <= '0;
            tx_sync <= '0;
        end else begin
            rx_sync <= {rx_sync[1:0], uart.rx_finish};
            tx_sync <= {tx_sync[1:0], uart.tx_finish};
        end
    end

    assign rx_evt = rx_sync[1] && !rx_sync[2];
    assign tx_evt = tx_sync[1] && !tx_sync[2];

    always_comb begin
        rx_byte = uart.rx_data;
        if (mode == MODE_UPPER && DATA_W == 8 &&
            uart.rx_data >= DATA_W'(ASCII_LOWER_A) &&
            uart.rx_data <= DATA_W'(ASCII_LOWER_Z))
            rx_byte = uart.rx_data - DATA_W'(ASCII_CASE_OFFSET);
    end

    assign accept   = rx_evt && !uart.rx_error && (mode != MODE_MUTE);
    assign wr_en    = accept && !full;
    assign ovf_drop = accept && full;

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (rx_byte),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow      <= 1'b0;
            pending_lines <= '0;
        end else begin
            if (ovf_drop) overflow <= 1'b1;
            case ({wr_en && (rx_byte == CR_CODE), pop && (head == CR_CODE)})
                2'b10:   pending_lines <= pending_lines + 1'b1;
                2'b01:   pending_lines <= pending_lines - 1'b1;
                default: pending_lines <= pending_lines;
            endcase
        end
    end

    // A full FIFO also releases in line mode, otherwise a line longer than DEPTH would deadlock.
    assign release_ok = !empty && ((mode != MODE_LINE) || (pending_lines != '0) || full);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            start_q  <= 1'b0;
            data_q   <= '0;
            seen_q   <= 1'b0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
            start_q  <= start_next;
            data_q   <= data_next;
            seen_q   <= seen_next;
        end
    end

    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        start_next = start_q;
        data_next  = data_q;
        seen_next  = seen_q;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (release_ok) begin
                    pop        = 1'b1;
                    data_next  = head;
                    start_next = 1'b1;
                    hold_next  = HW'(START_HOLD - 1);
                    seen_next  = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                // A fast TX may finish before the start pulse ends; remember it.
                if (tx_evt) seen_next = 1'b1;
                if (hold_cnt == '0) begin
                    start_next = 1'b0;
                    state_next = (seen_q || tx_evt) ? IDLE : WAIT;
                end else begin
                    hold_next = hold_cnt - 1'b1;
                end
            end
            WAIT: begin
                if (tx_evt) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign uart.tx_start = start_q;
    assign uart.tx_data  = data_q;
    assign busy          = !empty || (state != IDLE);

`ifdef UART_ECHO_ERRCNT_EN
    logic err_inc;
    assign err_inc = (rx_evt && uart.rx_error) || ovf_drop;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)
            err_count <= '0;
        else if (err_inc && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
    end
`else
`endif

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Randomised and directed bench for uart_echo_buffer against a queue-based
// model of the echo rules; checks err_count when UART_ECHO_ERRCNT_EN is defined.
module tb_uart_echo_buffer;

    localparam int         DEPTH = 4;
    localparam int         HOLD  = 1736;
    localparam logic [7:0] CR    = 8'h0D;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic [1:0]  mode    = 2'd0;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        busy;
`ifdef UART_ECHO_ERRCNT_EN
    logic [15:0] err_count;
`endif

    uart_echo_buffer_if #(.DATA_W(8)) uart();

    uart_echo_buffer #(
        .DATA_W     (8),
        .DEPTH      (DEPTH),
        .START_HOLD (HOLD),
        .CR_CODE    (CR)
    ) dut (
        .sys_clk    (sys_clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .uart       (uart),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .busy       (busy)
`ifdef UART_ECHO_ERRCNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: stored bytes, bytes owed to TX, and the sticky flags.
    logic [7:0] m_q[$];
    logic [7:0] exp_tx[$];
    int         m_pending = 0;
    bit         m_busy    = 1'b0;
    bit         m_ovf     = 1'b0;
    int         m_err     = 0;

    int         mon_len   = 0;
    bit         mon_prev  = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] upperRule(input logic [7:0] b, input logic [1:0] m);
        if (m == 2'd1 && b >= "a" && b <= "z") return b - 8'd32;
        return b;
    endfunction

    task automatic tryPop();
        logic [7:0] v;
        if (!m_busy && m_q.size() > 0 && (mode != 2'd2 || m_pending > 0 || m_q.size() == DEPTH)) begin
            v = m_q.pop_front();
            if (v == CR) m_pending--;
            exp_tx.push_back(v);
            m_busy = 1'b1;
        end
    endtask

    task automatic modelByte(input logic [7:0] data, input logic err);
        logic [7:0] v;
        if (err) begin
            m_err++;
        end else if (mode == 2'd3) begin
        end else if (m_q.size() == DEPTH) begin
            m_ovf = 1'b1;
            m_err++;
        end else begin
            v = upperRule(data, mode);
            m_q.push_back(v);
            if (v == CR) m_pending++;
            tryPop();
        end
    endtask

    task automatic modelReset();
        m_q.delete();
        exp_tx.delete();
        m_pending = 0;
        m_busy    = 1'b0;
        m_ovf     = 1'b0;
        m_err     = 0;
    endtask

    // Acts as UART_RX: one byte per rx_finish pulse, long enough to settle the DUT.
    task automatic applyStimulus(input logic [7:0] data, input logic err);
        modelByte(data, err);
        @(posedge sys_clk); #1;
        uart.rx_data   = data;
        uart.rx_error  = err;
        uart.rx_finish = 1'b1;
        repeat (6) @(posedge sys_clk);
        #1 uart.rx_finish = 1'b0;
        repeat (6) @(posedge sys_clk);
        #1;
    endtask

    task automatic waitStartLow();
        int n = 0;
        while (uart.tx_start === 1'b1 && n < HOLD + 200) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= HOLD + 200) checkOutput("tx_start_timeout", n, 0);
    endtask

    // Acts as UART_TX: either finishes during the start pulse or after it.
    task automatic finishTx(input bit early);
        bit use_early;
        use_early = early && (uart.tx_start === 1'b1) && (mon_len < HOLD - 100);
        if (!use_early) waitStartLow();
        @(posedge sys_clk); #1;
        uart.tx_finish = 1'b1;
        repeat (6) @(posedge sys_clk);
        #1 uart.tx_finish = 1'b0;
        if (use_early) waitStartLow();
        repeat (6) @(posedge sys_clk);
        #1;
        m_busy = 1'b0;
        tryPop();
    endtask

    task automatic setMode(input logic [1:0] m);
        @(posedge sys_clk); #1;
        mode = m;
        repeat (4) @(posedge sys_clk);
        #1;
        tryPop();
    endtask

    task automatic settleCheck(input string tag);
        @(negedge sys_clk);
        checkOutput({tag, ".count"}, fifo_count, m_q.size());
        checkOutput({tag, ".ovf"}, overflow, m_ovf);
        checkOutput({tag, ".busy"}, busy, (m_q.size() > 0 || m_busy));
`ifdef UART_ECHO_ERRCNT_EN
        checkOutput({tag, ".errcnt"}, err_count, (m_err > 65535) ? 65535 : m_err);
`endif
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 4 && m_busy; i++) finishTx(1'($urandom_range(0, 1)));
        settleCheck(tag);
    endtask

    // Every completed start pulse must be HOLD cycles long and carry the next owed byte.
    always @(negedge sys_clk) begin
        if (!rst_n) begin
            mon_prev = 1'b0;
            mon_len  = 0;
        end else begin
            if (uart.tx_start) mon_len = mon_len + 1;
            if (mon_prev && !uart.tx_start) begin
                checkOutput("start_len", mon_len, HOLD);
                if (exp_tx.size() == 0) checkOutput("tx_owed", exp_tx.size(), 1);
                else checkOutput("tx_data", uart.tx_data, exp_tx.pop_front());
                mon_len = 0;
            end
            mon_prev = uart.tx_start;
        end
    end

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] upper_in [4];
        logic [7:0] b;
        int         n;
        upper_in = '{8'h61, 8'h7A, 8'h5B, 8'h7B};

        uart.rx_finish = 1'b0;
        uart.rx_error  = 1'b0;
        uart.rx_data   = 8'h00;
        uart.tx_finish = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        checkOutput("rst_tx_start", uart.tx_start, 0);
        checkOutput("rst_tx_data", uart.tx_data, 0);
        checkOutput("rst_count", fifo_count, 0);
        checkOutput("rst_ovf", overflow, 0);
        checkOutput("rst_busy", busy, 0);
        @(posedge sys_clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge sys_clk);

        $display("[TB] echo single byte");
        applyStimulus(8'h41, 1'b0);
        settleCheck("echo1");
        checkOutput("echo_start", uart.tx_start, 1);
        finishTx(1'b0);
        settleCheck("echo_done");

        $display("[TB] burst with TX stalled");
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(8'(i), 1'b0);
            settleCheck("burst");
        end
        checkOutput("burst_peak", fifo_count, 4);
        drain("burst_drain");

        $display("[TB] uppercase and mute");
        setMode(2'd1);
        foreach (upper_in[i]) applyStimulus(upper_in[i], 1'b0);
        settleCheck("upper");
        drain("upper_drain");
        setMode(2'd3);
        applyStimulus(8'h55, 1'b0);
        settleCheck("mute");

        $display("[TB] line mode");
        setMode(2'd2);
        applyStimulus(8'h61, 1'b0);
        applyStimulus(8'h62, 1'b0);
        settleCheck("line_ab");
        checkOutput("line_hold", uart.tx_start, 0);
        applyStimulus(CR, 1'b0);
        settleCheck("line_cr");
        drain("line_drain");
        for (int i = 0; i < 3; i++) applyStimulus(8'h31 + 8'(i), 1'b0);
        @(negedge sys_clk);
        checkOutput("line_nocr_hold", uart.tx_start, 0);
        applyStimulus(8'h34, 1'b0);
        settleCheck("line_full");
        checkOutput("line_full_start", uart.tx_start, 1);
        drain("line_full_drain");
        setMode(2'd0);
        drain("line_release");

        $display("[TB] overflow and errors");
        for (int i = 0; i < 6; i++) applyStimulus(8'hA0 + 8'(i), 1'b0);
        settleCheck("ovf");
        checkOutput("ovf_flag", overflow, 1);
        checkOutput("ovf_count", fifo_count, 4);
        finishTx(1'b0);
        applyStimulus(8'hEE, 1'b1);
        applyStimulus(8'hEF, 1'b1);
        settleCheck("rx_err");
`ifdef UART_ECHO_ERRCNT_EN
        checkOutput("err_total", err_count, 3);
`endif

        $display("[TB] reset mid-START");
        finishTx(1'b1);
        n = 0;
        while (mon_len < 10 && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        checkOutput("pre_rst_start", uart.tx_start, 1);
        @(posedge sys_clk); #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_mid_start", uart.tx_start, 0);
        checkOutput("rst_mid_count", fifo_count, 0);
        checkOutput("rst_mid_ovf", overflow, 0);
        checkOutput("rst_mid_busy", busy, 0);
`ifdef UART_ECHO_ERRCNT_EN
        checkOutput("rst_mid_err", err_count, 0);
`endif
        repeat (3) @(posedge sys_clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge sys_clk);

        $display("[TB] randomised traffic");
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 3) == 0) setMode(2'($urandom_range(0, 3)));
            case ($urandom_range(0, 9))
                0, 1:       b = CR;
                2, 3, 4, 5: b = 8'($urandom_range(8'h61, 8'h7A));
                default:    b = 8'($urandom_range(0, 255));
            endcase
            applyStimulus(b, ($urandom_range(0, 7) == 0));
            settleCheck("rand");
            if (m_busy && $urandom_range(0, 1) == 1) begin
                finishTx(1'($urandom_range(0, 1)));
                settleCheck("rand_tx");
            end
        end
        setMode(2'd0);
        drain("final_drain");
        checkOutput("owed_left", exp_tx.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
